instr_encoder: RTL and testbench

//  Inverse of the immediate generator: packs decoded fields (format, opcode, rd, rs1, rs2, funct3, funct7, imm)

---
 rtl/instr_encoder_pkg.sv | 43 ++++
 rtl/instr_encoder_imm_pack.sv | 43 ++++
 rtl/instr_encoder.sv | 148 ++++++++++++++
 tb/tb_instr_encoder.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared constants for the RV32I instruction encoder: format codes, opcodes,
// the canonical NOP word, immediate range limits and the encoder FSM states.
package instr_encoder_pkg;

  localparam int INSTR_W = 32;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;

  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0013;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -(1 << 20);
  localparam int IMM21_MAX = (1 << 20) - 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } enc_state_e;

  function automatic logic imm_in_range(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Scatters a signed immediate into its per-format instruction bit positions and
// flags values the format cannot represent (range or alignment).
module rv_imm_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [31:0] i_imm,
  output logic [31:0] o_imm_bits,
  output logic        o_imm_err
);

  always_comb begin
    o_imm_bits = '0;
    o_imm_err  = 1'b0;
    case (i_fmt)
      FMT_I: begin
        o_imm_bits = {i_imm[11:0], 20'b0};
        o_imm_err  = !imm_in_range(i_imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_S: begin
        o_imm_bits = {i_imm[11:5], 13'b0, i_imm[4:0], 7'b0};
        o_imm_err  = !imm_in_range(i_imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_B: begin
        o_imm_bits = {i_imm[12], i_imm[10:5], 13'b0, i_imm[4:1], i_imm[11], 7'b0};
        o_imm_err  = !imm_in_range(i_imm, IMM13_MIN, IMM13_MAX) || i_imm[0];
      end
      FMT_U: begin
        o_imm_bits = {i_imm[31:12], 12'b0};
        o_imm_err  = |i_imm[11:0];
      end
      FMT_J: begin
        o_imm_bits = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'b0};
        o_imm_err  = !imm_in_range(i_imm, IMM21_MIN, IMM21_MAX) || i_imm[0];
      end
      default: begin
        o_imm_bits = '0;
        o_imm_err  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Counted-burst RV32I encoder: packs decoded fields into instruction words, each
// emitted through a one-deep output register together with its byte address.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [CNT_W-1:0]   burst_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         fmt,
  input  logic [6:0]         opcode,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic [31:0]        imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  out_addr,
  output logic               out_err,
  output logic [CNT_W-1:0]   err_cnt,
  output logic               busy,
  output logic               done,
  output logic [1:0]         dbg_state
);

  enc_state_e         r_state;
  enc_state_e         w_state_nxt;
  logic [CNT_W-1:0]   r_remaining;
  logic [ADDR_W-1:0]  r_addr;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_out_addr;
  logic               r_out_err;
  logic               r_out_valid;
  logic [CNT_W-1:0]   r_err_cnt;

  logic [31:0]        w_imm_bits;
  logic               w_imm_err;
  logic [INSTR_W-1:0] w_instr;
  logic               w_err;
  logic               w_accept;
  logic               w_drain;

  rv_imm_pack u_imm_pack (
    .i_fmt      (fmt),
    .i_imm      (imm),
    .o_imm_bits (w_imm_bits),
    .o_imm_err  (w_imm_err)
  );

  // Handshake: a transfer happens on a rising edge where valid && ready. The
  // producer holds its payload stable while valid && !ready; in_ready looks
  // through the output register so a word can be accepted in the same cycle
  // the previous one drains.
  assign in_ready = (r_state == ST_RUN) && (r_remaining != '0) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_drain  = r_out_valid && out_ready;

  always_comb begin
    w_instr = NOP_WORD;
    w_err   = 1'b1;
    case (fmt)
      FMT_R: begin
        w_instr = {funct7, rs2, rs1, funct3, rd, opcode};
        w_err   = 1'b0;
      end
      FMT_I: begin
        w_instr = w_imm_bits | {12'b0, rs1, funct3, rd, opcode};
        w_err   = w_imm_err;
      end
      FMT_S, FMT_B: begin
        w_instr = w_imm_bits | {7'b0, rs2, rs1, funct3, 5'b0, opcode};
        w_err   = w_imm_err;
      end
      FMT_U, FMT_J: begin
        w_instr = w_imm_bits | {20'b0, rd, opcode};
        w_err   = w_imm_err;
      end
      default: begin
        w_instr = NOP_WORD;
        w_err   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // With nothing left to accept, the word in the output register is the last one.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = (burst_len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_drain && (r_remaining == '0)) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining <= '0;
      r_addr      <= '0;
      r_instr     <= '0;
      r_out_addr  <= '0;
      r_out_err   <= 1'b0;
      r_out_valid <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      if ((r_state == ST_IDLE) && start) begin
        r_remaining <= burst_len;
        r_addr      <= base_addr;
        r_err_cnt   <= '0;
      end
      if (w_accept) begin
        r_remaining <= r_remaining - CNT_W'(1);
        r_addr      <= r_addr + ADDR_W'(4);
        r_instr     <= w_instr;
        r_out_addr  <= r_addr;
        r_out_err   <= w_err;
        r_out_valid <= 1'b1;
        if (w_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_W'(1);
      end else if (w_drain) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign instr     = r_instr;
  assign out_addr  = r_out_addr;
  assign out_err   = r_out_err;
  assign err_cnt   = r_err_cnt;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: randomized and directed bursts, reference encoding
// model, expected-word queue drained by an independent output monitor.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;
  localparam int EXP_W  = 101;  // {fmt, imm, last, err, addr, instr}

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  burst_len;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [6:0]        opcode;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;
  logic [CNT_W-1:0]  err_cnt;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  instr_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .burst_len(burst_len),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode), .rd(rd),
    .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .out_addr(out_addr),
    .out_err(out_err), .err_cnt(err_cnt), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared state ----------------
  int               checks = 0;
  int               failures = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [31:0]      exp_addr = '0;
  int               burst_errs = 0;
  int               cyc = 0;
  int               zl_done_cyc = -1;
  int               bp_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [32:0] model_encode(input logic [2:0] f, input logic [6:0] opc,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] im);
    int v;
    logic e;
    logic [31:0] w;
    v = int'(im);
    e = 1'b0;
    case (f)
      3'd0: w = {f7, s2, s1, f3, d, opc};
      3'd1: begin w = {im[11:0], s1, f3, d, opc}; e = (v < -2048) || (v > 2047); end
      3'd2: begin w = {im[11:5], s2, s1, f3, im[4:0], opc}; e = (v < -2048) || (v > 2047); end
      3'd3: begin
        w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], opc};
        e = (v < -4096) || (v > 4094) || (v % 2 != 0);
      end
      3'd4: begin w = {im[31:12], d, opc}; e = (im % 4096) != 0; end
      3'd5: begin
        w = {im[20], im[10:1], im[11], im[19:12], d, opc};
        e = (v < -(1 << 20)) || (v > (1 << 20) - 2) || (v % 2 != 0);
      end
      default: begin w = 32'h0000_0013; e = 1'b1; end
    endcase
    return {e, w};
  endfunction

  // Standard RV32I immediate generator, used to prove the round trip.
  function automatic logic [31:0] imm_gen(input logic [2:0] f, input logic [31:0] i);
    case (f)
      3'd1:    return {{20{i[31]}}, i[31:20]};
      3'd2:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd3:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd4:    return {i[31:12], 12'b0};
      3'd5:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- output backpressure ----------------
  initial begin
    int stalled;
    stalled = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        0: begin out_ready = 1'b1; stalled = 0; end
        1: begin out_ready = ($urandom_range(0, 3) != 0); stalled = 0; end
        2: begin
          if (out_valid && (out_addr == 32'h4) && (stalled < 3)) begin
            out_ready = 1'b0;
            stalled++;
          end else out_ready = 1'b1;
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EXP_W-1:0] e;
    logic             done_due;
    logic             exp_done;
    logic             held_valid;
    logic [31:0]      held_instr;
    logic [31:0]      held_addr;
    done_due = 1'b0;
    held_valid = 1'b0;
    held_instr = '0;
    held_addr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        done_due = 1'b0;
        held_valid = 1'b0;
      end else begin
        exp_done = done_due || (cyc == zl_done_cyc);
        if (done || exp_done) check("done_pulse", 32'(done), 32'(exp_done));
        done_due = 1'b0;
        if (held_valid) begin
          check("hold_instr", instr, held_instr);
          check("hold_addr", out_addr, held_addr);
        end
        if (out_valid && !out_ready) check("in_ready_stall", 32'(in_ready), 32'd0);
        held_valid = out_valid && !out_ready;
        held_instr = instr;
        held_addr = out_addr;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 32'(out_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("instr", instr, e[31:0]);
            check("out_addr", out_addr, e[63:32]);
            check("out_err", 32'(out_err), 32'(e[64]));
            if (!e[64] && (e[100:98] != 3'd0))
              check("imm_roundtrip", imm_gen(e[100:98], instr), e[97:66]);
            if (e[65]) done_due = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_burst(input logic [31:0] base, input logic [15:0] len);
    start = 1'b1;
    base_addr = base;
    burst_len = len;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = base;
    burst_errs = 0;
    if (len == 0) zl_done_cyc = cyc + 1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] opc, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] im, input logic last);
    int waits;
    logic [32:0] m;
    fmt = f; opcode = opc; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    m = model_encode(f, opc, d, s1, s2, f3, f7, im);
    exp_q.push_back({f, im, last, m[32], exp_addr, m[31:0]});
    exp_addr = exp_addr + 32'd4;
    if (m[32]) burst_errs++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_random(input logic last);
    int r;
    int v;
    logic [2:0]  f;
    logic [31:0] im;
    r = int'($urandom_range(0, 13));
    f = (r < 12) ? 3'(r % 6) : 3'(r - 6);
    v = int'($urandom);
    if ($urandom_range(0, 3) != 0) begin
      case (f)
        3'd1, 3'd2: v = int'($urandom_range(0, 4095)) - 2048;
        3'd3:       v = (int'($urandom_range(0, 4095)) - 2048) * 2;
        3'd4:       v = int'($urandom) & 32'hFFFF_F000;
        3'd5:       v = (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2;
        default:    v = int'($urandom);
      endcase
    end
    im = 32'(v);
    drive(f, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
          7'($urandom), im, last);
  endtask

  task automatic wait_idle();
    int waits;
    waits = 0;
    @(negedge clk);
    while (busy && waits < 500) begin
      waits++;
      @(negedge clk);
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
    check("err_cnt_burst", 32'(err_cnt), 32'(burst_errs));
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_out_addr"}, out_addr, 32'd0);
    check({tag, "_out_err"}, 32'(out_err), 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; burst_len = '0; in_valid = 1'b0;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    #1;
    check_reset_values("reset");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // ADDI x1, x0, -1
    start_burst(32'h100, 16'd1);
    drive(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b1);
    wait_idle();

    // branch: legal -4, then misaligned 3
    start_burst(32'h0, 16'd2);
    drive(FMT_B, OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b0);
    drive(FMT_B, OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b1);
    wait_idle();

    // JAL x1, 2048 and LUI x5, 0x12345
    start_burst(32'h200, 16'd2);
    drive(FMT_J, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0);
    drive(FMT_U, OPC_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1);
    wait_idle();

    // output stall on the second word
    bp_mode = 2;
    start_burst(32'h0, 16'd4);
    for (int i = 0; i < 4; i++) drive_random(i == 3);
    wait_idle();
    bp_mode = 0;

    // zero-length burst
    start_burst(32'h40, 16'd0);
    @(negedge clk);
    check("zero_len_no_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    wait_idle();

    // start during RUN is ignored
    start_burst(32'h300, 16'd2);
    start = 1'b1; base_addr = 32'h500; burst_len = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    drive_random(1'b0);
    drive_random(1'b1);
    wait_idle();

    // address wrap
    start_burst(32'hFFFF_FFFC, 16'd2);
    drive_random(1'b0);
    drive_random(1'b1);
    wait_idle();

    // asynchronous reset with a word pending
    bp_mode = 3;
    start_burst(32'h80, 16'd3);
    drive(FMT_I, OPC_OP_IMM, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd5000, 1'b0);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    check("pre_reset_err_cnt", 32'(err_cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    bp_mode = 1;
    @(posedge clk); #1;

    // randomized bursts with random backpressure and input gaps
    for (int b = 0; b < 30; b++) begin
      int len;
      len = int'($urandom_range(1, 12));
      start_burst($urandom & 32'hFFFF_FFFC, 16'(len));
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        drive_random(i == len - 1);
      end
      wait_idle();
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
